dmem_ctrl: RTL and testbench

//  Parametrised byte-addressed data memory with valid/ready request and response channels, configurable wait states,
//  and load sign/zero extension for 8/16/32/64-bit accesses. Serves the core's load/store unit.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_if.sv | 20 ++
 rtl/dmem_lane_fmt.sv | 24 ++
 rtl/dmem_ctrl.sv | 111 +++++++++++
 tb/tb_dmem_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size and FSM types for the data memory controller
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int WAIT_CNT_W = 4;
  function automatic int nbytes(size_e s);
    return 1 << s;
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channels of the data memory
interface dmem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import dmem_pkg::*;
  logic              req_valid, req_ready, req_we, req_signed;
  size_e             req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, resp_rdata;
  logic              resp_valid, resp_ready, resp_err;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte-enable mask and load extension for an access within one data-width word
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LB = $clog2(NB)
) (
  input  size_e             size,
  input  logic [LB-1:0]     lane,
  input  logic              sgn,
  input  logic [DATA_W-1:0] raw,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] data
);
  logic [63:0] s;
  always_comb begin
    be   = NB'(((1 << nbytes(size)) - 1) << lane);
    s    = 64'(raw >> {lane, 3'b000});
    data = DATA_W'(size == SZ_B ? {{56{sgn & s[7]}}, s[7:0]} :
                   size == SZ_H ? {{48{sgn & s[15]}}, s[15:0]} :
                   size == SZ_W ? {{32{sgn & s[31]}}, s[31:0]} : s);
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with wait states, load extension and a registered fetch port
// DMEM_ERR_EN: report misaligned/out-of-range/oversized accesses instead of aligning and wrapping
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int SIZE        = 65536,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_if.slave             bus,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       inst,
  output logic              i_available_o
);
  localparam int AW = $clog2(SIZE);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  logic [7:0] mem [SIZE];
  state_e state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, sgn_q;
  size_e size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic accept, commit, direct, c_we, c_sgn, c_err;
  size_e c_size, c_sz;
  logic [ADDR_W-1:0] c_addr, a, ia;
  logic [DATA_W-1:0] c_wdata, raw, ext, wd;
  logic [AW-1:0] base;
  logic [LB-1:0] lane;
  logic [NB-1:0] be;
  logic unused_ok;
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign accept  = state_q == IDLE && bus.req_valid;
  // without wait states the access commits on its accept edge, straight from the bus
  assign direct  = state_q == IDLE;
  assign c_we    = direct ? bus.req_we : we_q;
  assign c_sgn   = direct ? bus.req_signed : sgn_q;
  assign c_size  = direct ? bus.req_size : size_q;
  assign c_addr  = direct ? bus.req_addr : addr_q;
  assign c_wdata = direct ? bus.req_wdata : wdata_q;
  assign ia = {i_addr[ADDR_W-1:2], 2'b00};
  assign unused_ok = ^{a[ADDR_W-1:AW], i_addr[1:0]};
  always_comb begin
    commit  = rst_n && (WAIT_CYCLES == 0 ? accept : state_q == WAIT && cnt_q == '0);
    state_d = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
              state_q == WAIT && cnt_q == '0 ? RESP :
              state_q == RESP && bus.resp_ready ? IDLE : state_q;
    cnt_d   = accept ? WAIT_CNT_W'(WAIT_CYCLES - 1) : cnt_q - 1'b1;
  end
  always_comb begin
`ifdef DMEM_ERR_EN
    c_sz  = c_size;
    a     = c_addr;
    c_err = (DATA_W == 32 && c_size == SZ_D) || (c_addr & ADDR_W'(nbytes(c_size) - 1)) != '0 ||
            64'(c_addr) + 64'(nbytes(c_size)) > 64'(SIZE);
`else
    c_sz  = DATA_W == 32 && c_size == SZ_D ? SZ_W : c_size;
    a     = c_addr & ~ADDR_W'(nbytes(c_sz) - 1);
    c_err = 1'b0;
`endif
    base = a[AW-1:0] & ~AW'(NB - 1);
    lane = a[LB-1:0];
    wd   = c_wdata << {lane, 3'b000};
    raw  = '0;
    for (int i = 0; i < NB; i++) raw[8*i +: 8] = mem[base | AW'(i)];
  end
  dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size(c_sz), .lane(lane), .sgn(c_sgn), .raw(raw), .be(be), .data(ext)
  );
  always_ff @(posedge clk)
    if (commit && c_we && !c_err)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[base | AW'(i)] <= wd[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      we_q            <= 1'b0;
      sgn_q           <= 1'b0;
      size_q          <= SZ_B;
      addr_q          <= '0;
      wdata_q         <= '0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      inst            <= '0;
      i_available_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        bus.resp_rdata <= c_we || c_err ? '0 : ext;
        bus.resp_err   <= c_err;
      end
      inst <= 64'(ia) < 64'(SIZE) ? {mem[{ia[AW-1:2], 2'd3}], mem[{ia[AW-1:2], 2'd2}],
                                     mem[{ia[AW-1:2], 2'd1}], mem[{ia[AW-1:2], 2'd0}]} : '0;
      i_available_o <= i_valid;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of a 32-bit zero-wait instance and a 64-bit three-wait instance
module tb_dmem_ctrl;
  import dmem_pkg::*;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, i_valid;
  logic [31:0] i_addr, inst_a, inst_b;
  logic iav_a, iav_b;
  int n_chk = 0;
  int n_fail = 0;
  dmem_if #(.ADDR_W(32), .DATA_W(32)) ba ();
  dmem_if #(.ADDR_W(32), .DATA_W(64)) bb ();
  dmem_ctrl #(.SIZE(65536), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba), .i_valid(i_valid), .i_addr(i_addr),
    .inst(inst_a), .i_available_o(iav_a)
  );
  dmem_ctrl #(.SIZE(65536), .ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb), .i_valid(i_valid), .i_addr(i_addr),
    .inst(inst_b), .i_available_o(iav_b)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic acc(input bit sel, input string tag, input logic we, input size_e sz,
                     input logic sg, input logic [31:0] ad, input logic [63:0] wd,
                     input logic [63:0] exp_rd, input logic exp_er, input int hold);
    int lat;
    ba.req_we = we; ba.req_size = sz; ba.req_signed = sg; ba.req_addr = ad; ba.req_wdata = wd[31:0];
    bb.req_we = we; bb.req_size = sz; bb.req_signed = sg; bb.req_addr = ad; bb.req_wdata = wd;
    if (sel) bb.req_valid = 1'b1; else ba.req_valid = 1'b1;
    chk({tag, "_ready"}, sel ? bb.req_ready : ba.req_ready, 64'd1);
    @(posedge clk);
    #1 ba.req_valid = 1'b0;
    bb.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(sel ? bb.resp_valid : ba.resp_valid) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), sel ? 64'd4 : 64'd1);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_valid"}, sel ? bb.resp_valid : ba.resp_valid, 64'd1);
      chk({tag, "_busy"}, sel ? bb.req_ready : ba.req_ready, 64'd0);
      chk({tag, "_rdata"}, sel ? bb.resp_rdata : 64'(ba.resp_rdata), exp_rd);
      chk({tag, "_err"}, sel ? bb.resp_err : ba.resp_err, 64'(exp_er));
    end
    ba.resp_ready = 1'b1;
    bb.resp_ready = 1'b1;
    @(posedge clk);
    #1 ba.resp_ready = 1'b0;
    bb.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, sel ? bb.resp_valid : ba.resp_valid, 64'd0);
  endtask
  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_addr = 32'h10;
    ba.req_valid = 1'b0; ba.req_we = 1'b0; ba.req_size = SZ_B; ba.req_signed = 1'b0;
    ba.req_addr = '0; ba.req_wdata = '0; ba.resp_ready = 1'b0;
    bb.req_valid = 1'b0; bb.req_we = 1'b0; bb.req_size = SZ_B; bb.req_signed = 1'b0;
    bb.req_addr = '0; bb.req_wdata = '0; bb.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_a", ba.req_ready, 64'd1);
    chk("rst_valid_a", ba.resp_valid, 64'd0);
    chk("rst_rdata_a", 64'(ba.resp_rdata), 64'd0);
    chk("rst_err_a", ba.resp_err, 64'd0);
    chk("rst_inst_a", inst_a, 64'd0);
    chk("rst_iav_a", iav_a, 64'd0);
    chk("rst_ready_b", bb.req_ready, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    i_valid = 1'b1;
    @(negedge clk);
    chk("iav_set", iav_a, 64'd1);
    acc(0, "sw_pre", 1, SZ_W, 0, 32'h10, 64'h11223344, 64'h0, 0, 0);
    ba.req_we = 1'b1; ba.req_size = SZ_W; ba.req_addr = 32'h10; ba.req_wdata = 32'hDEADBEEF;
    ba.resp_ready = 1'b1; ba.req_valid = 1'b1;
    @(posedge clk);
    #1 ba.req_valid = 1'b0;
    @(negedge clk);
    chk("fetch_old", inst_a, 64'h11223344);
    chk("sw_valid", ba.resp_valid, 64'd1);
    @(posedge clk);
    #1 ba.resp_ready = 1'b0;
    @(negedge clk);
    chk("fetch_new", inst_a, 64'hDEADBEEF);
    chk("sw_done", ba.resp_valid, 64'd0);
    acc(0, "lw", 0, SZ_W, 0, 32'h10, 64'h0, 64'hDEADBEEF, 0, 0);
    acc(0, "lb", 0, SZ_B, 1, 32'h10, 64'h0, 64'hFFFFFFEF, 0, 0);
    acc(0, "lbu", 0, SZ_B, 0, 32'h13, 64'h0, 64'h000000DE, 0, 0);
    acc(0, "lh", 0, SZ_H, 1, 32'h12, 64'h0, 64'hFFFFDEAD, 0, 0);
    acc(0, "lhu", 0, SZ_H, 0, 32'h10, 64'h0, 64'h0000BEEF, 0, 0);
    acc(0, "sb", 1, SZ_B, 0, 32'h11, 64'h5A, 64'h0, 0, 0);
    acc(0, "lw_sb", 0, SZ_W, 0, 32'h10, 64'h0, 64'hDEAD5AEF, 0, 0);
    acc(0, "sw_mis", 1, SZ_W, 0, 32'h11, 64'hCAFEF00D, 64'h0, ERR, 0);
    acc(0, "lw_mis", 0, SZ_W, 0, 32'h10, 64'h0, ERR ? 64'hDEAD5AEF : 64'hCAFEF00D, 0, 0);
    acc(0, "ld_w32", 0, SZ_D, 0, 32'h10, 64'h0, ERR ? 64'h0 : 64'hCAFEF00D, ERR, 0);
    acc(0, "sw_top", 1, SZ_W, 0, 32'hFFFC, 64'h55667788, 64'h0, 0, 0);
    acc(0, "lw_edge", 0, SZ_W, 0, 32'hFFFE, 64'h0, ERR ? 64'h0 : 64'h55667788, ERR, 0);
    acc(0, "lw_wrap", 0, SZ_W, 0, 32'h10010, 64'h0,
        ERR ? 64'h0 : 64'hCAFEF00D, ERR, 0);
    acc(1, "sd", 1, SZ_D, 0, 32'h20, 64'h0123456789ABCDEF, 64'h0, 0, 5);
    acc(1, "ld", 0, SZ_D, 0, 32'h20, 64'h0, 64'h0123456789ABCDEF, 0, 0);
    acc(1, "lw_hi", 0, SZ_W, 1, 32'h24, 64'h0, 64'h0000000001234567, 0, 0);
    acc(1, "lw_lo", 0, SZ_W, 1, 32'h20, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 0);
    acc(1, "lbu64", 0, SZ_B, 0, 32'h27, 64'h0, 64'h01, 0, 0);
    acc(1, "lh64", 0, SZ_H, 1, 32'h22, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, 0);
    acc(1, "sw64", 1, SZ_W, 0, 32'h24, 64'hAABBCCDD, 64'h0, 0, 0);
    acc(1, "ld_sw", 0, SZ_D, 0, 32'h20, 64'h0, 64'hAABBCCDD89ABCDEF, 0, 0);
    ba.req_we = 1'b0; ba.req_size = SZ_W; ba.req_signed = 1'b0; ba.req_addr = 32'h10; ba.req_valid = 1'b1;
    bb.req_we = 1'b1; bb.req_size = SZ_D; bb.req_addr = 32'h20; bb.req_wdata = '1; bb.req_valid = 1'b1;
    @(posedge clk);
    #1 ba.req_valid = 1'b0;
    bb.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid_a", ba.resp_valid, 64'd1);
    chk("pre_rst_busy_b", bb.req_ready, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_a", ba.resp_valid, 64'd0);
    chk("mid_rst_rdata_a", 64'(ba.resp_rdata), 64'd0);
    chk("mid_rst_ready_b", bb.req_ready, 64'd1);
    chk("mid_rst_valid_b", bb.resp_valid, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acc(1, "ld_after_rst", 0, SZ_D, 0, 32'h20, 64'h0, 64'hAABBCCDD89ABCDEF, 0, 0);
    i_addr = 32'h10010;
    @(negedge clk);
    chk("fetch_oob", inst_a, 64'd0);
    i_valid = 1'b0;
    @(negedge clk);
    chk("iav_clr", iav_a, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
